// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and constants for the serial arithmetic blocks
//
// Purpose : FSM state encoding and default operand width used by serial_subtractor.
// Contents: sub_state_t {IDLE, SHIFT, DONE}, SUB_WIDTH_DEF.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - one-bit combinational full subtractor
//
// Purpose : Diff = A - B - Bin for a single bit, with borrow-out.
// Ports   : A    in  minuend bit
//           B    in  subtrahend bit
//           Bin  in  borrow-in
//           Diff out difference bit
//           Bout out borrow-out
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  assign Diff = A ^ B ^ Bin;
  // Borrow when B exceeds A outright, or when they are equal and a borrow ripples in.
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, diff = a - b - bin
//
// Purpose : Processes one bit per cycle, LSB first, over WIDTH cycles.
//           Operands load in parallel and the result is returned in parallel.
//           The block uses a start/busy/done handshake.
// Params  : WIDTH (2..32) operand/result width.
// Ports   : clk   in  rising-edge clock
//           rst   in  synchronous active-high reset
//           start in  request, sampled when not busy (IDLE or DONE)
//           a, b  in  minuend / subtrahend, captured on an accepted start
//           bin   in  borrow-in, captured on an accepted start
//           busy  out high during the WIDTH shift cycles
//           done  out one-cycle pulse when diff/bout/ovf are valid
//           diff  out result, held from done until the next result lands
//           bout  out final borrow-out (unsigned underflow)
//           ovf   out signed overflow; built only with SERIAL_SUBTRACTOR_OVF_EN, else tied 0
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CNT_W-1:0] cnt;
  logic             brw;
  logic             d_bit;
  logic             brw_next;
  logic             last_bit;

  full_subtractor u_fs (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Bin  (brw),
    .Diff (d_bit),
    .Bout (brw_next)
  );

  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);
  assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {d_bit, res_sr[WIDTH-1:1]};
      brw    <= brw_next;
      cnt    <= cnt + CNT_W'(1);
      if (last_bit) begin
        // Only the final bit publishes to diff, so partial results never appear.
        state <= DONE;
        diff  <= {d_bit, res_sr[WIDTH-1:1]};
        bout  <= brw_next;
      end
    end else if (start) begin
      // IDLE and DONE both accept; from DONE this gives back-to-back operation.
      state <= SHIFT;
      a_sr  <= a;
      b_sr  <= b;
      brw   <= bin;
      cnt   <= '0;
    end else begin
      state <= IDLE;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // On the last bit the shift registers hold the operand MSBs, so no separate
  // capture of the sign bits is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (last_bit) begin
      ovf <= (a_sr[0] ^ b_sr[0]) & (d_bit ^ a_sr[0]);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  int total;
  int bad;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one operation and waits (bounded) for done. lat counts cycles from
  // the accepting edge to the done cycle; busy_n counts busy cycles seen;
  // stable is cleared if diff moves before done.
  task automatic do_op(input logic [7:0] ai, input logic [7:0] bi, input logic bini,
                       output logic [7:0] d, output logic bo, output logic ov,
                       output int busy_n, output int lat, output logic stable);
    logic [7:0] held;
    @(negedge clk);
    a = ai; b = bi; bin = bini; start = 1'b1;
    held = diff;
    @(posedge clk);
    #1 start = 1'b0;
    a = 8'hxx; b = 8'hxx; bin = 1'bx;
    lat = 0; busy_n = 0; stable = 1'b1;
    while (1) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (done) break;
      if (diff !== held) stable = 1'b0;
      if (lat > 40) break;
    end
    d = diff; bo = bout; ov = ovf;
  endtask

  function automatic logic exp_ovf(input logic [7:0] ai, input logic [7:0] bi, input logic [7:0] d);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    return (ai[7] != bi[7]) && (d[7] != ai[7]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, diff, bout, ovf} !== 12'h000) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy, done, diff, bout, ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] d; logic bo, ov, st; int bn, lat;
    do_op(8'h05, 8'h03, 1'b0, d, bo, ov, bn, lat, st);
    total++; if (lat !== 9) begin bad++; $display("FAIL basic_latency: got %0d want 9", lat); end
    total++; if (bn !== 8) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 8", bn); end
    total++; if (d !== 8'h02) begin bad++; $display("FAIL basic_diff: got %h want 02", d); end
    total++; if (bo !== 1'b0) begin bad++; $display("FAIL basic_bout: got %b want 0", bo); end
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL basic_ovf: got %b want 0", ov); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_borrow();
    logic [7:0] d; logic bo, ov, st; int bn, lat;
    do_op(8'h03, 8'h05, 1'b0, d, bo, ov, bn, lat, st);
    total++; if (d !== 8'hFE) begin bad++; $display("FAIL borrow_diff: got %h want fe", d); end
    total++; if (bo !== 1'b1) begin bad++; $display("FAIL borrow_bout: got %b want 1", bo); end
    do_op(8'h00, 8'h00, 1'b1, d, bo, ov, bn, lat, st);
    total++; if (d !== 8'hFF) begin bad++; $display("FAIL binonly_diff: got %h want ff", d); end
    total++; if (bo !== 1'b1) begin bad++; $display("FAIL binonly_bout: got %b want 1", bo); end
  endtask

  task automatic test_ovf();
    logic [7:0] d; logic bo, ov, st; int bn, lat;
    logic want;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    do_op(8'h80, 8'h01, 1'b0, d, bo, ov, bn, lat, st);
    total++; if (d !== 8'h7F) begin bad++; $display("FAIL ovf1_diff: got %h want 7f", d); end
    total++; if (bo !== 1'b0) begin bad++; $display("FAIL ovf1_bout: got %b want 0", bo); end
    total++; if (ov !== want) begin bad++; $display("FAIL ovf1_flag: got %b want %b", ov, want); end
    do_op(8'h10, 8'h01, 1'b0, d, bo, ov, bn, lat, st);
    total++; if (d !== 8'h0F) begin bad++; $display("FAIL ovf2_diff: got %h want 0f", d); end
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL ovf2_flag: got %b want 0", ov); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a = 8'h20; b = 8'h10; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 a = 8'h09; b = 8'h0A;   // start stays high throughout SHIFT
    lat = 0;
    do begin @(negedge clk); lat++; end while (!done && lat < 40);
    total++; if (lat !== 9) begin bad++; $display("FAIL b2b_first_latency: got %0d want 9", lat); end
    total++; if (diff !== 8'h10) begin bad++; $display("FAIL b2b_first_diff: got %h want 10", diff); end
    total++; if (bout !== 1'b0) begin bad++; $display("FAIL b2b_first_bout: got %b want 0", bout); end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
    lat = 1;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    total++; if (lat !== 9) begin bad++; $display("FAIL b2b_second_latency: got %0d want 9", lat); end
    total++; if (diff !== 8'hFF) begin bad++; $display("FAIL b2b_second_diff: got %h want ff", diff); end
    total++; if (bout !== 1'b1) begin bad++; $display("FAIL b2b_second_bout: got %b want 1", bout); end
  endtask

  task automatic test_abort();
    logic [7:0] d; logic bo, ov, st; int bn, lat; int seen;
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);   // now in the 4th SHIFT cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, done, diff, bout} !== 11'h000) begin
      bad++;
      $display("FAIL abort_state: got busy=%b done=%b diff=%h bout=%b, want all 0", busy, done, diff, bout);
    end
    seen = 0;
    repeat (15) begin @(negedge clk); if (done) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
    do_op(8'h40, 8'h11, 1'b0, d, bo, ov, bn, lat, st);
    total++; if (d !== 8'h2F) begin bad++; $display("FAIL abort_fresh_diff: got %h want 2f", d); end
    total++; if (bo !== 1'b0) begin bad++; $display("FAIL abort_fresh_bout: got %b want 0", bo); end
  endtask

  task automatic test_sweep();
    logic [7:0] d, ai, bi; logic bo, ov, st, bini; int bn, lat;
    logic [8:0] ref9;
    for (int i = 0; i < 1000; i++) begin
      ai = 8'($urandom); bi = 8'($urandom); bini = 1'($urandom);
      do_op(ai, bi, bini, d, bo, ov, bn, lat, st);
      ref9 = {1'b0, ai} - {1'b0, bi} - {8'h00, bini};
      total++;
      if (lat !== 9 || d !== ref9[7:0] || bo !== ref9[8] || ov !== exp_ovf(ai, bi, ref9[7:0])) begin
        bad++;
        $display("FAIL sweep_result a=%h b=%h bin=%b: got diff=%h bout=%b ovf=%b lat=%0d want diff=%h bout=%b ovf=%b lat=9",
                 ai, bi, bini, d, bo, ov, lat, ref9[7:0], ref9[8], exp_ovf(ai, bi, ref9[7:0]));
      end
      total++;
      if (st !== 1'b1) begin
        bad++;
        $display("FAIL sweep_diff_stable a=%h b=%h: got diff changed before done, want held", ai, bi);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_ovf();
    test_back_to_back();
    test_abort();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing diff = a - b - bin over WIDTH clock cycles, LSB first.
- It is the inverse arithmetic direction of the team's ripple adder datapath.
- Used on the breadboard for brightness decrement and fade-down paths, where area matters more than latency.
- Operands load in parallel. The result is returned in parallel with a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk    in   1      rising-edge clock
- rst    in   1      synchronous reset, active-high
- start  in   1      request; sampled only when not busy
- a      in   WIDTH  minuend; captured on an accepted start
- b      in   WIDTH  subtrahend; captured on an accepted start
- bin    in   1      borrow-in; captured on an accepted start
- busy   out  1      high while bits are being processed
- done   out  1      single-cycle pulse when the result is valid
- diff   out  WIDTH  result; held stable from done until the next accepted start
- bout   out  1      final borrow-out (1 when a < b + bin, unsigned)
- ovf    out  1      signed overflow flag; see Optional Feature

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: state = IDLE; busy = 0, done = 0, diff = 0, bout = 0, ovf = 0; internal shift registers, bit counter and borrow flop all cleared.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: if start=1, capture a, b and bin (bin goes into the borrow flop), clear the counter, go to SHIFT. Otherwise stay.
  - SHIFT: busy=1. Each cycle:
    - d = a_sr[0] ^ b_sr[0] ^ brw
    - brw_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw)
    - shift a_sr and b_sr right one bit
    - shift d into the result register at the MSB
    - increment the counter
    - when the counter reaches WIDTH-1, go to DONE after this cycle.
  - DONE: done=1 for exactly one cycle and busy=0. diff and bout are valid and registered.
    - If start=1 in this cycle, it is accepted as in IDLE and the FSM goes straight to SHIFT (back-to-back operation).
    - Otherwise go to IDLE.
- Latency: start accepted at edge k → busy high for cycles k+1..k+WIDTH → done high in cycle k+WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored; the operation in flight is unaffected.
- a, b and bin are don't-care except on the accepting edge.
- diff and bout are updated only at the SHIFT→DONE transition. The result register is internal while shifting, so diff never shows partial results.
- rst during SHIFT aborts the operation. The next cycle is in IDLE with all outputs 0, and no done pulse is produced.
- Wrap-around: the result is modulo 2^WIDTH. bout carries the unsigned underflow.
- Width rules: the counter is $clog2(WIDTH) bits wide. There is no sign extension.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN
- Defined: ovf is registered at SHIFT→DONE as the signed overflow of the operation. ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands. ovf is held with diff.
- Undefined: ovf is tied to 0, and no extra flops or capture logic are built. The port is present in both builds.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state enum type sub_state_t {IDLE, SHIFT, DONE}
  - default width constant SUB_WIDTH_DEF = 8
- One combinational sub-module, full_subtractor (ports A, B, Bin, Diff, Bout), implements the per-bit equations above. It is instantiated once inside the SHIFT datapath.

Test Plan:
- WIDTH=8; a=0x05, b=0x03, bin=0, start for one cycle → done in cycle 9 after acceptance; diff=0x02, bout=0, busy high exactly 8 cycles.
- a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1. Also a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
- Signed overflow:
  - macro on: a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1; then a=0x10, b=0x01 → ovf=0.
  - macro off: ovf=0 for both operations.
- start held high with different operands throughout SHIFT → a second operation begins only in the DONE cycle. First result a=0x20, b=0x10 → 0x10, then back-to-back result a=0x09, b=0x0A → 0xFF, bout=1.
- Assert rst in the 4th SHIFT cycle → next cycle is IDLE with busy=0, done=0, diff=0, bout=0; no done pulse follows. A fresh start then produces a correct result.
- Randomised sweep of 1000 operands (a, b, bin) checked against a reference model of (a - b - bin) mod 256 and the borrow. diff must not change between done pulses.
